mmss_timer_ctrl: RTL and testbench



---
 rtl/mmss_timer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mmss_timer_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mmss_timer_ctrl.sv
// MM:SS countdown / count-up timer with a one-second prescaler, start/pause control,
// BCD preset sanitising, a one-cycle done pulse and a 4-digit 7-segment display scanner.
module mmss_timer_ctrl #(
    parameter int TICK_DIV       = 50_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        new_clock,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  preset_mm,
    input  logic [7:0]  preset_ss,
    input  logic        mode,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        stop,
    output logic        done,
    output logic [3:0]  digit_sel,
    output logic [6:0]  Mostrador
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     cnt, cnt_nxt, target, cnt_inc, cnt_dec, preset_san;
    logic            up;
    logic [PW-1:0]   presc, presc_nxt;
    logic            done_q;
    logic            tick, at_end;
    logic [SW-1:0]   scan_cnt;
    logic [1:0]      idx;
    logic [3:0]      digit;
    logic [6:0]      seg;

    function automatic logic [7:0] sanitise(input logic [7:0] v);
        return {(v[7:4] > 4'd5) ? 4'd5 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
                else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (v[15:12] != 4'd5) ? v[15:12] + 4'd1 : 4'd0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign preset_san = {sanitise(preset_mm), sanitise(preset_ss)};
    assign cnt_inc    = bcd_inc(cnt);
    assign cnt_dec    = bcd_dec(cnt);

    // Command priority is load > pause > start; the tick only advances on edges with no command.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        presc_nxt = presc;
        tick      = (presc == PW'(TICK_DIV - 1));
        at_end    = up ? (cnt == target) : (cnt == 16'h0000);
        if (load) begin
            state_nxt = IDLE;
            cnt_nxt   = mode ? 16'h0000 : preset_san;
            presc_nxt = '0;
        end else if (pause) begin
            if (state == RUN) state_nxt = PAUSED;
        end else if (start && (state == IDLE || state == PAUSED)) begin
            if (state == IDLE) presc_nxt = '0;
            state_nxt = at_end ? DONE : RUN;
        end else if (state == RUN) begin
            if (tick) begin
                presc_nxt = '0;
                cnt_nxt   = up ? cnt_inc : cnt_dec;
                if (up ? (cnt_inc == target) : (cnt_dec == 16'h0000)) state_nxt = DONE;
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge new_clock) begin
        if (clear) begin
            state  <= IDLE;
            cnt    <= '0;
            target <= '0;
            up     <= 1'b0;
            presc  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            presc  <= presc_nxt;
            done_q <= (state_nxt == DONE) && (state != DONE);
            if (load) begin
                target <= preset_san;
                up     <= mode;
            end
        end
    end

    // Scanner runs regardless of timer state; only clear restarts it.
    always_ff @(posedge new_clock) begin
        if (clear) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        case (idx)
            2'd0:    digit = cnt[3:0];
            2'd1:    digit = cnt[7:4];
            2'd2:    digit = cnt[11:8];
            default: digit = cnt[15:12];
        endcase
        seg = seg7(digit);
    end

    assign digit_sel = 4'b0001 << idx;
    assign Mostrador = SEG_ACTIVE_LOW ? ~seg : seg;
    assign time_bcd  = cnt;
    assign running   = (state == RUN);
    assign stop      = (state == DONE);
    assign done      = done_q;
endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Bench for mmss_timer_ctrl: directed test-plan sequences plus random commands, every cycle
// compared against a seconds-based reference model of the timer and display.
module tb_mmss_timer_ctrl;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        clear = 1'b0, load = 1'b0, mode = 1'b0, start = 1'b0, pause = 1'b0;
    logic [7:0]  preset_mm = 8'h00, preset_ss = 8'h00;
    logic [15:0] time_bcd, time_bcd1;
    logic        running, stop, done, running1, stop1, done1;
    logic [3:0]  digit_sel, digit_sel1;
    logic [6:0]  seg0, seg1;

    int n_chk = 0, n_err = 0;

    // reference model state
    int m_state, m_secs, m_tgt, m_cyc;
    bit m_up, m_done;
    int m_elapsed;
    logic [6:0] codes [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    always #5 clk = ~clk;

    mmss_timer_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .new_clock(clk), .clear(clear), .load(load), .preset_mm(preset_mm), .preset_ss(preset_ss),
        .mode(mode), .start(start), .pause(pause), .time_bcd(time_bcd), .running(running),
        .stop(stop), .done(done), .digit_sel(digit_sel), .Mostrador(seg0));

    mmss_timer_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .new_clock(clk), .clear(clear), .load(load), .preset_mm(preset_mm), .preset_ss(preset_ss),
        .mode(mode), .start(start), .pause(pause), .time_bcd(time_bcd1), .running(running1),
        .stop(stop1), .done(done1), .digit_sel(digit_sel1), .Mostrador(seg1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int san_secs(input logic [7:0] mm, input logic [7:0] ss);
        int mt, mu, st, su;
        mt = (mm[7:4] > 5) ? 5 : int'(mm[7:4]);
        mu = (mm[3:0] > 9) ? 9 : int'(mm[3:0]);
        st = (ss[7:4] > 5) ? 5 : int'(ss[7:4]);
        su = (ss[3:0] > 9) ? 9 : int'(ss[3:0]);
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic bit finished();
        return m_up ? (m_secs == m_tgt) : (m_secs == 0);
    endfunction

    task automatic model_edge();
        bit pulse;
        pulse = 1'b0;
        if (clear) begin
            m_state = S_IDLE; m_secs = 0; m_tgt = 0; m_up = 1'b0; m_elapsed = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            if (load) begin
                m_tgt = san_secs(preset_mm, preset_ss);
                m_up = mode;
                m_secs = mode ? 0 : m_tgt;
                m_state = S_IDLE;
                m_elapsed = 0;
            end else if (pause) begin
                if (m_state == S_RUN) m_state = S_PAUSED;
            end else if (start && (m_state == S_IDLE || m_state == S_PAUSED)) begin
                if (m_state == S_IDLE) m_elapsed = 0;
                if (finished()) begin m_state = S_DONE; pulse = 1'b1; end
                else m_state = S_RUN;
            end else if (m_state == S_RUN) begin
                m_elapsed++;
                if (m_elapsed == TD) begin
                    m_elapsed = 0;
                    m_secs = m_up ? (m_secs + 1) % 3600 : m_secs - 1;
                    if (finished()) begin m_state = S_DONE; pulse = 1'b1; end
                end
            end
        end
        m_done = pulse;
    endtask

    task automatic step();
        logic [15:0] b;
        int di;
        logic [6:0] code, inv;
        @(posedge clk);
        model_edge();
        #1;
        b = to_bcd(m_secs);
        di = (m_cyc / SD) % 4;
        code = codes[b[di*4 +: 4]];
        inv = ~code;
        chk("time", time_bcd, b);
        chk("running", running, m_state == S_RUN);
        chk("stop", stop, m_state == S_DONE);
        chk("done", done, m_done);
        chk("digit_sel", digit_sel, 4'b0001 << di);
        chk("seg", seg0, code);
        chk("seg_inv", seg1, inv);
        chk("time_inv_dut", time_bcd1, b);
    endtask

    task automatic do_load(input logic [7:0] mm, input logic [7:0] ss, input logic md);
        load = 1'b1; preset_mm = mm; preset_ss = ss; mode = md;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        step(); step();
        clear = 1'b0;
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_sel", digit_sel, 4'b0001);
        chk("rst_seg", seg0, 7'b0111111);

        // down count 00:03
        do_load(8'h00, 8'h03, 1'b0);
        chk("load_003", time_bcd, 16'h0003);
        do_start();
        repeat (3 * TD + 2) step();
        chk("down_stop", stop, 1'b1);
        chk("down_end", time_bcd, 16'h0000);

        // borrow chain
        do_load(8'h10, 8'h00, 1'b0); do_start(); repeat (TD) step();
        chk("borrow_0959", time_bcd, 16'h0959);
        do_load(8'h01, 8'h00, 1'b0); do_start(); repeat (TD) step();
        chk("borrow_0059", time_bcd, 16'h0059);

        // up mode to 00:02 and carry 00:59 -> 01:00
        do_load(8'h00, 8'h02, 1'b1);
        chk("up_load", time_bcd, 16'h0000);
        do_start(); repeat (2 * TD + 2) step();
        chk("up_stop", stop, 1'b1);
        do_load(8'h59, 8'h59, 1'b1); do_start(); repeat (59 * TD) step();
        chk("up_0059", time_bcd, 16'h0059);
        repeat (TD) step();
        chk("up_0100", time_bcd, 16'h0100);

        // pause/resume: two counted cycles before pause, tick two cycles after resume
        do_load(8'h00, 8'h05, 1'b0); do_start(); step(); step();
        pause = 1'b1; repeat (10) step(); pause = 1'b0;
        chk("paused_hold", time_bcd, 16'h0005);
        do_start(); step();
        chk("resume_before", time_bcd, 16'h0005);
        step();
        chk("resume_tick", time_bcd, 16'h0004);

        // sanitise, load+start priority, clear during run
        do_load(8'h7C, 8'hFA, 1'b0);
        chk("sanitise", time_bcd, 16'h5959);
        load = 1'b1; start = 1'b1; step(); load = 1'b0; start = 1'b0;
        chk("load_over_start", running, 1'b0);
        do_start(); repeat (TD + 1) step();
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear_time", time_bcd, 16'h0000);
        chk("clear_done", done, 1'b0);

        // zero-length run and display of 42:17
        do_load(8'h00, 8'h00, 1'b0); do_start();
        chk("zero_len_done", done, 1'b1);
        do_load(8'h42, 8'h17, 1'b0);
        repeat (16) step();

        // random phase
        for (int i = 0; i < 1500; i++) begin
            clear = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 5) == 0);
            mode = 1'($urandom_range(0, 1));
            preset_mm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            preset_ss = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            step();
        end
        clear = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
